// File: rtl/xosera_video_pkg.sv
// Shared constants, types and helpers for the Xosera 640x480 video core.
// Timing defaults, register map, CTRL bit positions and the colour-bar lookup.
package xosera_video_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;

   localparam int CNT_W     = 10;
   localparam int REG_NUM_W = 4;
   localparam int NUM_REGS  = 16;
   localparam int BAR_W     = 80;

   localparam logic [REG_NUM_W-1:0] REG_BGCOLOR  = 4'h0;
   localparam logic [REG_NUM_W-1:0] REG_CTRL     = 4'h1;
   localparam logic [REG_NUM_W-1:0] REG_INTR     = 4'h2;
   localparam logic [REG_NUM_W-1:0] REG_SCANLINE = 4'h3;
   localparam logic [REG_NUM_W-1:0] REG_AUDIO    = 4'h4;

   localparam int CTRL_ENABLE   = 0;
   localparam int CTRL_BARS     = 1;
   localparam int CTRL_VSYNC_IE = 2;
   localparam int CTRL_BOOT_LSB = 13;
   localparam int CTRL_BOOT_MSB = 14;
   localparam int CTRL_RECONFIG = 15;

   typedef logic [11:0] rgb_t;

   typedef enum logic {
      BYTE_HI = 1'b0,
      BYTE_LO = 1'b1
   } bytesel_e;

   // One sampled snapshot of the host bus, carried through the synchronizer
   typedef struct packed {
      logic                 cs_n;
      logic                 rd_nwr;
      logic [REG_NUM_W-1:0] reg_num;
      bytesel_e             bytesel;
      logic [7:0]           data;
   } bus_req_t;

   localparam bus_req_t BUS_IDLE = '{cs_n: 1'b1, rd_nwr: 1'b1, reg_num: '0,
                                     bytesel: BYTE_HI, data: '0};

   // Eight 80-pixel bars; compare chain avoids a divider on h
   function automatic rgb_t bar_color(input logic [CNT_W-1:0] h);
      logic [2:0] bar;
      rgb_t       c;
      bar = '0;
      for (int i = 1; i < 8; i++) begin
         if (h >= CNT_W'(i * BAR_W)) bar = 3'(i);
      end
      case (bar)
         3'd0:    c = 12'hFFF;
         3'd1:    c = 12'hFF0;
         3'd2:    c = 12'h0FF;
         3'd3:    c = 12'h0F0;
         3'd4:    c = 12'hF0F;
         3'd5:    c = 12'hF00;
         3'd6:    c = 12'h00F;
         default: c = 12'h000;
      endcase
      bar_color = c;
   endfunction

endpackage

// File: rtl/xosera_video_core_if.sv
// Host byte-lane register bus. The host side drives strobes and write data;
// the core returns registered read data.
interface xosera_bus_if;
   import xosera_video_pkg::*;

   logic                 cs_n;
   logic                 rd_nwr;
   logic [REG_NUM_W-1:0] reg_num;
   logic                 bytesel;
   logic [7:0]           wdata;
   logic [7:0]           rdata;

   modport master (output cs_n, rd_nwr, reg_num, bytesel, wdata, input rdata);
   modport slave  (input cs_n, rd_nwr, reg_num, bytesel, wdata, output rdata);

endinterface

// File: rtl/xosera_video_core_timing.sv
// Raster counters plus registered sync/data-enable, one clk behind the counters.
// Also exposes the combinational visible flag and the vsync-start pulse.
module video_timing
   import xosera_video_pkg::*;
#(
   parameter int H_VIS_P   = H_VISIBLE,
   parameter int H_FP_P    = H_FP,
   parameter int H_SYNC_P  = H_SYNC,
   parameter int H_BP_P    = H_BP,
   parameter int V_VIS_P   = V_VISIBLE,
   parameter int V_FP_P    = V_FP,
   parameter int V_SYNC_P  = V_SYNC,
   parameter int V_BP_P    = V_BP
) (
   input  logic             clk,
   input  logic             reset_i,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             visible,
   output logic             vsync_start,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             de_o
);

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS_P + H_FP_P + H_SYNC_P + H_BP_P - 1);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VIS_P);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS_P + H_FP_P);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS_P + H_FP_P + H_SYNC_P);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS_P + V_FP_P + V_SYNC_P + V_BP_P - 1);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VIS_P);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS_P + V_FP_P);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS_P + V_FP_P + V_SYNC_P);

   logic hs_act;
   logic vs_act;

   assign visible     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
   assign vsync_start = (h_cnt == '0) && (v_cnt == VS_START);
   assign hs_act      = (h_cnt >= HS_START) && (h_cnt < HS_END);
   assign vs_act      = (v_cnt >= VS_START) && (v_cnt < VS_END);

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         h_cnt   <= '0;
         v_cnt   <= '0;
         hsync_o <= 1'b1;
         vsync_o <= 1'b1;
         de_o    <= 1'b0;
      end else begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
         // Syncs are negative polarity
         hsync_o <= ~hs_act;
         vsync_o <= ~vs_act;
         de_o    <= visible;
      end
   end

endmodule

// File: rtl/xosera_video_core.sv
// Xosera video core top: bus synchronizer, 16x16 register file, pixel
// colour generation, vsync interrupt and two PDM audio channels.
module xosera_video_core
   import xosera_video_pkg::*;
#(
   parameter int H_VIS_P  = H_VISIBLE,
   parameter int H_FP_P   = H_FP,
   parameter int H_SYNC_P = H_SYNC,
   parameter int H_BP_P   = H_BP,
   parameter int V_VIS_P  = V_VISIBLE,
   parameter int V_FP_P   = V_FP,
   parameter int V_SYNC_P = V_SYNC,
   parameter int V_BP_P   = V_BP
) (
   input  logic              clk,
   input  logic              reset_i,
   xosera_bus_if.slave       bus,
   output logic              bus_intr_o,
   output logic [3:0]        red_o,
   output logic [3:0]        green_o,
   output logic [3:0]        blue_o,
   output logic              hsync_o,
   output logic              vsync_o,
   output logic              dv_de_o,
   output logic              audio_l_o,
   output logic              audio_r_o,
   output logic              reconfig_o,
   output logic [1:0]        boot_select_o
);

   bus_req_t         req_raw;
   bus_req_t         req_s1;
   bus_req_t         req_s2;
   logic             cs_n_d;
   logic             wr_stb;
   logic             wr_mapped;
   logic             intr_clr;
   logic             pending;
   logic [15:0]      regs [NUM_REGS];
   logic [15:0]      rd_word;
   logic [8:0]       acc_l;
   logic [8:0]       acc_r;
   rgb_t             pix;

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             visible;
   logic             vsync_start;

   video_timing #(
      .H_VIS_P (H_VIS_P),  .H_FP_P (H_FP_P),  .H_SYNC_P (H_SYNC_P),  .H_BP_P (H_BP_P),
      .V_VIS_P (V_VIS_P),  .V_FP_P (V_FP_P),  .V_SYNC_P (V_SYNC_P),  .V_BP_P (V_BP_P)
   ) u_timing (
      .clk         (clk),
      .reset_i     (reset_i),
      .h_cnt       (h_cnt),
      .v_cnt       (v_cnt),
      .visible     (visible),
      .vsync_start (vsync_start),
      .hsync_o     (hsync_o),
      .vsync_o     (vsync_o),
      .de_o        (dv_de_o)
   );

   always_comb begin
      req_raw = '{cs_n: bus.cs_n, rd_nwr: bus.rd_nwr, reg_num: bus.reg_num,
                  bytesel: bytesel_e'(bus.bytesel), data: bus.wdata};
   end

   // Whole bus snapshot goes through two flops; the host holds data stable
   // across the chip-select window, so per-bit skew cannot corrupt a write.
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         req_s1 <= BUS_IDLE;
         req_s2 <= BUS_IDLE;
         cs_n_d <= 1'b1;
      end else begin
         req_s1 <= req_raw;
         req_s2 <= req_s1;
         cs_n_d <= req_s2.cs_n;
      end
   end

   assign wr_stb    = cs_n_d && !req_s2.cs_n && !req_s2.rd_nwr;
   assign wr_mapped = (req_s2.reg_num != REG_INTR) && (req_s2.reg_num != REG_SCANLINE);
   assign intr_clr  = wr_stb && (req_s2.reg_num == REG_INTR) &&
                      (req_s2.bytesel == BYTE_LO) && req_s2.data[0];

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_stb && wr_mapped) begin
         if (req_s2.bytesel == BYTE_HI) regs[req_s2.reg_num][15:8] <= req_s2.data;
         else                           regs[req_s2.reg_num][7:0]  <= req_s2.data;
      end
   end

   // Set beats clear so a frame boundary is never lost to a racing ack
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         pending    <= 1'b0;
         bus_intr_o <= 1'b0;
      end else begin
         if (vsync_start)   pending <= 1'b1;
         else if (intr_clr) pending <= 1'b0;
         bus_intr_o <= pending && regs[REG_CTRL][CTRL_VSYNC_IE];
      end
   end

   always_comb begin
      rd_word = regs[req_s2.reg_num];
      case (req_s2.reg_num)
         REG_INTR:     rd_word = {15'b0, pending};
         REG_SCANLINE: rd_word = {{(16-CNT_W){1'b0}}, v_cnt};
         default:      ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i)                       bus.rdata <= '0;
      else if (req_s2.bytesel == BYTE_HI) bus.rdata <= rd_word[15:8];
      else                                bus.rdata <= rd_word[7:0];
   end

   always_comb begin
      pix = '0;
      if (visible && regs[REG_CTRL][CTRL_ENABLE]) begin
         pix = regs[REG_CTRL][CTRL_BARS] ? bar_color(h_cnt) : regs[REG_BGCOLOR][11:0];
      end
   end

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) {red_o, green_o, blue_o} <= '0;
      else          {red_o, green_o, blue_o} <= pix;
   end

   // First-order PDM: the carry out of an 8-bit phase accumulator is the bitstream
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         acc_l <= '0;
         acc_r <= '0;
      end else begin
         acc_l <= {1'b0, acc_l[7:0]} + {1'b0, regs[REG_AUDIO][15:8]};
         acc_r <= {1'b0, acc_r[7:0]} + {1'b0, regs[REG_AUDIO][7:0]};
      end
   end

   assign audio_l_o     = acc_l[8];
   assign audio_r_o     = acc_r[8];
   assign reconfig_o    = regs[REG_CTRL][CTRL_RECONFIG];
   assign boot_select_o = regs[REG_CTRL][CTRL_BOOT_MSB:CTRL_BOOT_LSB];

endmodule

// File: tb/tb_xosera_video_core.sv
// Directed bench for xosera_video_core with a shortened vertical raster;
// horizontal timing stays at the full 800-clock line.
module tb_xosera_video_core;
   import xosera_video_pkg::*;

   localparam int TV_VIS  = 8;
   localparam int TV_FP   = 2;
   localparam int TV_SYNC = 2;
   localparam int TV_BP   = 2;
   localparam int LINE    = 800;
   localparam int FRAME   = LINE * (TV_VIS + TV_FP + TV_SYNC + TV_BP);
   localparam logic HI = 1'b0;
   localparam logic LO = 1'b1;

   localparam int   BAR_PX  [8] = '{0, 79, 80, 159, 240, 400, 480, 639};
   localparam rgb_t BAR_EXP [8] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'hFF0,
                                    12'h0F0, 12'hF00, 12'h00F, 12'h000};

   logic       clk = 1'b0;
   logic       reset_i = 1'b0;
   logic       bus_intr_o, hsync_o, vsync_o, dv_de_o;
   logic       audio_l_o, audio_r_o, reconfig_o;
   logic [3:0] red_o, green_o, blue_o;
   logic [1:0] boot_select_o;
   logic [7:0] rd;
   int         n_chk = 0;
   int         n_fail = 0;

   xosera_bus_if bus ();

   xosera_video_core #(
      .V_VIS_P (TV_VIS), .V_FP_P (TV_FP), .V_SYNC_P (TV_SYNC), .V_BP_P (TV_BP)
   ) dut (
      .clk           (clk),
      .reset_i       (reset_i),
      .bus           (bus),
      .bus_intr_o    (bus_intr_o),
      .red_o         (red_o),
      .green_o       (green_o),
      .blue_o        (blue_o),
      .hsync_o       (hsync_o),
      .vsync_o       (vsync_o),
      .dv_de_o       (dv_de_o),
      .audio_l_o     (audio_l_o),
      .audio_r_o     (audio_r_o),
      .reconfig_o    (reconfig_o),
      .boot_select_o (boot_select_o)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [3:0] r, input logic bs, input logic [7:0] d);
      bus.rd_nwr = 1'b0; bus.reg_num = r; bus.bytesel = bs; bus.wdata = d;
      step(1);
      bus.cs_n = 1'b0;
      step(4);
      bus.cs_n = 1'b1;
      step(3);
   endtask

   task automatic bus_read(input logic [3:0] r, input logic bs, output logic [7:0] d);
      bus.rd_nwr = 1'b1; bus.reg_num = r; bus.bytesel = bs;
      step(4);
      d = bus.rdata;
   endtask

   function automatic logic [11:0] rgb();
      rgb = {red_o, green_o, blue_o};
   endfunction

   task automatic chk_reset(input string p);
      chk({p, "_hsync"},  32'(hsync_o), 32'd1);
      chk({p, "_vsync"},  32'(vsync_o), 32'd1);
      chk({p, "_de"},     32'(dv_de_o), 32'd0);
      chk({p, "_rgb"},    32'(rgb()), 32'd0);
      chk({p, "_rdata"},  32'(bus.rdata), 32'd0);
      chk({p, "_intr"},   32'(bus_intr_o), 32'd0);
      chk({p, "_audio"},  32'({audio_l_o, audio_r_o}), 32'd0);
      chk({p, "_reconf"}, 32'(reconfig_o), 32'd0);
      chk({p, "_boot"},   32'(boot_select_o), 32'd0);
   endtask

   // Releases reset on a falling edge; the first visible line starts right away
   task automatic chk_first_line(input string p);
      reset_i = 1'b1;
      step(1);
      chk({p, "_de_px0"}, 32'(dv_de_o), 32'd1);
      step(639);
      chk({p, "_de_px639"}, 32'(dv_de_o), 32'd1);
      step(1);
      chk({p, "_de_px640"}, 32'(dv_de_o), 32'd0);
   endtask

   task automatic wait_de_rise(input string tag);
      logic prev;
      bit   got;
      got  = 1'b0;
      prev = dv_de_o;
      for (int i = 0; i < FRAME && !got; i++) begin
         step(1);
         if (!prev && dv_de_o) got = 1'b1;
         prev = dv_de_o;
      end
      chk(tag, 32'(got), 32'd1);
   endtask

   initial begin
      int   hs_f0, hs_f1, hs_r0, vs_f0, vs_f1, vs_r0, de_lines, de_cyc, cnt_l, cnt_r, pos;
      logic p_hs, p_vs, p_de;
      bit   rgb_nz, got;

      bus.cs_n = 1'b1; bus.rd_nwr = 1'b1; bus.reg_num = '0; bus.bytesel = 1'b0; bus.wdata = '0;
      step(3);
      chk_reset("rst");
      chk_first_line("l0");

      // Raster measurement over more than one frame
      hs_f0 = -1; hs_f1 = -1; hs_r0 = -1; vs_f0 = -1; vs_f1 = -1; vs_r0 = -1;
      de_lines = 0; de_cyc = 0; rgb_nz = 1'b0;
      p_hs = hsync_o; p_vs = vsync_o; p_de = dv_de_o;
      for (int c = 0; c < 2 * FRAME - 1000; c++) begin
         step(1);
         if (p_hs && !hsync_o) begin
            if (hs_f0 < 0) hs_f0 = c; else if (hs_f1 < 0) hs_f1 = c;
         end
         if (!p_hs && hsync_o && hs_f0 >= 0 && hs_r0 < 0) hs_r0 = c;
         if (p_vs && !vsync_o) begin
            if (vs_f0 < 0) vs_f0 = c; else if (vs_f1 < 0) vs_f1 = c;
         end
         if (!p_vs && vsync_o && vs_f0 >= 0 && vs_r0 < 0) vs_r0 = c;
         if (vs_f0 >= 0 && vs_f1 < 0) begin
            if (dv_de_o) de_cyc++;
            if (!p_de && dv_de_o) de_lines++;
         end
         if (rgb() != 12'h000) rgb_nz = 1'b1;
         p_hs = hsync_o; p_vs = vsync_o; p_de = dv_de_o;
      end
      chk("hs_period", 32'(hs_f1 - hs_f0), 32'(LINE));
      chk("hs_low",    32'(hs_r0 - hs_f0), 32'd96);
      chk("vs_period", 32'(vs_f1 - vs_f0), 32'(FRAME));
      chk("vs_low",    32'(vs_r0 - vs_f0), 32'(TV_SYNC * LINE));
      chk("de_lines",  32'(de_lines), 32'(TV_VIS));
      chk("de_cycles", 32'(de_cyc), 32'(TV_VIS * 640));
      chk("rgb_off",   32'(rgb_nz), 32'd0);

      bus_read(4'd15, HI, rd); chk("r15_hi_rst", 32'(rd), 32'h00);
      bus_read(4'd15, LO, rd); chk("r15_lo_rst", 32'(rd), 32'h00);

      // Solid background
      bus_write(REG_BGCOLOR, HI, 8'h0A);
      bus_write(REG_BGCOLOR, LO, 8'hBC);
      bus_write(REG_CTRL, LO, 8'h01);
      bus_read(REG_BGCOLOR, HI, rd); chk("r0_hi", 32'(rd), 32'h0A);
      bus_read(REG_BGCOLOR, LO, rd); chk("r0_lo", 32'(rd), 32'hBC);
      wait_de_rise("bg_de_wait");
      chk("bg_px0", 32'(rgb()), 32'hABC);
      step(639);
      chk("bg_px639", 32'(rgb()), 32'hABC);
      step(1);
      chk("bg_px640", 32'(rgb()), 32'h000);

      // Colour bars
      bus_write(REG_CTRL, LO, 8'h03);
      wait_de_rise("bar_de_wait");
      pos = 0;
      for (int k = 0; k < 8; k++) begin
         step(BAR_PX[k] - pos);
         pos = BAR_PX[k];
         chk($sformatf("bar_px%0d", pos), 32'(rgb()), 32'(BAR_EXP[k]));
      end
      step(1);
      chk("bar_px640", 32'(rgb()), 32'h000);

      // Vsync interrupt: drop any stale pending before enabling
      bus_write(REG_INTR, LO, 8'h01);
      bus_write(REG_CTRL, LO, 8'h05);
      chk("intr_idle", 32'(bus_intr_o), 32'd0);
      got = 1'b0;
      for (int i = 0; i < FRAME + 100 && !got; i++) begin
         step(1);
         if (bus_intr_o) got = 1'b1;
      end
      chk("intr_rise", 32'(got), 32'd1);
      chk("intr_vsync", 32'(vsync_o), 32'd0);
      bus_read(REG_SCANLINE, LO, rd); chk("r3_line", 32'(rd), 32'(TV_VIS + TV_FP));
      bus_read(REG_INTR, LO, rd);     chk("r2_pend", 32'(rd), 32'h01);
      bus_write(REG_INTR, LO, 8'h01);
      chk("intr_clr", 32'(bus_intr_o), 32'd0);
      bus_read(REG_INTR, LO, rd);     chk("r2_clr", 32'(rd), 32'h00);

      // Scratch register byte lanes
      bus_write(4'd7, HI, 8'h12);
      bus_write(4'd7, LO, 8'h34);
      bus_read(4'd7, HI, rd); chk("r7_hi", 32'(rd), 32'h12);
      bus_read(4'd7, LO, rd); chk("r7_lo", 32'(rd), 32'h34);
      bus_write(4'd7, LO, 8'h56);
      bus_read(4'd7, HI, rd); chk("r7_hi_keep", 32'(rd), 32'h12);
      bus_read(4'd7, LO, rd); chk("r7_lo_new", 32'(rd), 32'h56);

      // PDM audio duty over one full accumulator period
      bus_write(REG_AUDIO, HI, 8'h80);
      step(2);
      cnt_l = 0; cnt_r = 0;
      for (int i = 0; i < 256; i++) begin
         step(1);
         if (audio_l_o) cnt_l++;
         if (audio_r_o) cnt_r++;
      end
      chk("aud_l_half", 32'(cnt_l), 32'd128);
      chk("aud_r_zero", 32'(cnt_r), 32'd0);
      bus_write(REG_AUDIO, LO, 8'hFF);
      step(2);
      cnt_r = 0;
      for (int i = 0; i < 256; i++) begin
         step(1);
         if (audio_r_o) cnt_r++;
      end
      chk("aud_r_ff", 32'(cnt_r), 32'd255);

      // Reconfig / boot select
      bus_write(REG_CTRL, HI, 8'hC0);
      chk("reconfig", 32'(reconfig_o), 32'd1);
      chk("boot_sel", 32'(boot_select_o), 32'd2);
      bus_read(REG_CTRL, LO, rd); chk("ctrl_lo_keep", 32'(rd), 32'h05);

      // Mid-frame reset
      reset_i = 1'b0;
      #1;
      chk_reset("mrst");
      step(1);
      chk_first_line("l1");
      bus_read(4'd7, LO, rd);         chk("r7_after_rst", 32'(rd), 32'h00);
      bus_read(REG_SCANLINE, LO, rd); chk("r3_after_rst", 32'(rd), 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/xosera_video_core.md
Name: xosera_video_core

Overview:
- Bus-programmable 640x480@60 VGA display engine, one pixel clock domain (25.175 MHz nominal, supplied by the board PLL).
- Exposes an 8-bit byte-lane register interface (16 x 16-bit registers) to a host CPU.
- Generates sync, data-enable and 4:4:4 RGB (solid background or colour bars), a vsync interrupt, two 1-bit PDM audio outputs and reconfiguration/boot-select strobes.

Parameters:
H_VISIBLE 640 active pixels; H_FP 16; H_SYNC 96; H_BP 48 (total 800)
V_VISIBLE 480 active lines; V_FP 10; V_SYNC 2; V_BP 33 (total 525)

Ports:
clk  in  1  pixel clock, all logic rising-edge
reset_i  in  1  asynchronous, active-low reset
bus_cs_n_i  in  1  chip select, active low, asynchronous to clk
bus_rd_nwr_i  in  1  1=read, 0=write
bus_reg_num_i  in  4  register index
bus_bytesel_i  in  1  0=high byte [15:8], 1=low byte [7:0]
bus_data_i  in  8  write data
bus_data_o  out  8  read data
bus_intr_o  out  1  interrupt, active high
red_o/green_o/blue_o  out  4 each  pixel colour
hsync_o, vsync_o  out  1  negative-polarity syncs
dv_de_o  out  1  data enable (visible area)
audio_l_o, audio_r_o  out  1  PDM audio
reconfig_o  out  1  FPGA reconfigure request
boot_select_o  out  2  boot image select

Behaviour:
- Reset (reset_i=0, async): all registers 0, counters 0, hsync_o=vsync_o=1, RGB=0, dv_de_o=0, bus_data_o=0, intr/audio/reconfig=0, boot_select_o=0.
- Bus sync: cs_n, rd_nwr, reg_num, bytesel and data pass through a 2-FF synchronizer. A write fires on the synchronized cs_n 1->0 edge with rd_nwr=0. The register updates 3 clk after cs_n falls. Exactly one write per cs_n assertion.
- Byte writes update only the selected byte of the selected register.
- Reads: bus_data_o is registered every clk from the synchronized reg_num/bytesel and selects the corresponding byte. Unmapped registers read 0.
- Registers:
  - R0 BGCOLOR [11:0] = RGB (R=[11:8]).
  - R1 CTRL: bit0 video enable; bit1 colour-bar mode; bit2 vsync interrupt enable; bits[14:13] boot_select; bit15 reconfig.
  - R2 INTR: bit0 vsync pending; writing 1 to bit0 clears it.
  - R3 SCANLINE: read-only, current v count.
  - R4 AUDIO: [15:8] left level, [7:0] right level.
  - R5..R15: 16-bit scratch, read/write.
- Timing: h counter 0..799 wraps to 0; v counter increments at h wrap, 0..524 wraps to 0.
  - hsync_o=0 for h in 656..751.
  - vsync_o=0 for v in 490..491.
  - dv_de_o=1 for h<640 and v<480.
  - All video outputs registered with one stage of latency versus the counters.
- Pixel colour when de=1 and enable=1:
  - Colour-bar mode: 8 bars of 80 pixels, bar=h/80, colours FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Otherwise BGCOLOR.
  - RGB=0 when de=0 or enable=0.
- Interrupt: pending is set when h=0 and v=490. If set and clear occur in the same cycle, set wins. bus_intr_o = pending & CTRL[2], registered.
- Audio: per channel, 9-bit accumulator acc <= acc[7:0] + level; the output is the carry bit acc[8]. Level 0 gives constant 0; level FF gives a 255/256 duty cycle.
- reconfig_o mirrors CTRL[15] and boot_select_o mirrors CTRL[14:13]. There is no self-clear.
- Register writes take effect on the next pixel. A mid-frame reset restarts the frame at h=v=0.

Decomposition:
- Package xosera_video_pkg: register index constants, CTRL bit positions, timing localparams, colour-bar lookup.
- Sub-module video_timing: owns the counters, sync, de and the vsync-start pulse.
- The bus interface, register file and PDM logic stay in the top module.

Test Plan:
- Reset release, run 2 frames: hsync period 800 clk, low 96; vsync period 420000 clk, low 1600; de high 640 per line on 480 lines.
- Write R0 hi=0x0A, lo=0xBC, then R1 lo=0x01: visible pixels show R=A, G=B, B=C; blanking pixels show 0.
- Write CTRL lo=0x03: pixel 0 gives FFF, pixel 80 gives FF0, pixel 639 gives 000.
- CTRL lo=0x05: bus_intr_o rises at line 490. Read R2 lo returns 0x01. Write R2 lo=0x01: intr drops within 4 clk.
- Write R7=0x1234, read back hi 0x12 and lo 0x34. Read R15 after reset returns 0x00.
- R4=0x8000 → audio_l_o duty 50%, audio_r_o constant 0. CTRL hi=0xC0 → reconfig_o=1, boot_select_o=2.
